// File: rtl/cpu_sram_axi_bridge_if.sv
// ---------------------------------------------------------------------------
// cpu_sram_axi_bridge_if
// Single-beat AXI4 bus seen by the CPU SRAM-to-AXI bridge.
//   master modport : the bridge (drives AR/AW/W, R/B ready)
//   slave  modport : the SoC bus / memory model
// Signals
//   araddr/arlen/arsize/arburst/arvalid/arready : read address channel
//   rdata/rvalid/rready                         : read data channel
//   awaddr/awlen/awsize/awburst/awvalid/awready : write address channel
//   wdata/wstrb/wlast/wvalid/wready             : write data channel
//   bvalid/bready                               : write response channel
// rlast and bresp are not carried; the bridge only issues single beats and
// ignores the response code.
// ---------------------------------------------------------------------------
interface cpu_sram_axi_bridge_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [31:0]       rdata;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_sram_axi_bridge.sv
// ---------------------------------------------------------------------------
// cpu_sram_axi_bridge
// Bridges the CPU inst_sram / data_sram request ports onto a single-beat AXI4
// bus. Data requests win arbitration over fetches; one transaction is in
// flight at a time.
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   inst_req/inst_addr   : fetch request, held until inst_data_ok
//   inst_rdata           : fetched word, valid with inst_data_ok
//   inst_data_ok         : 1-cycle fetch completion pulse
//   data_req/data_wen/data_addr/data_wdata : load/store request, held until
//                          data_data_ok; data_wen == 0 means load
//   data_rdata           : load data, valid with data_data_ok
//   data_data_ok         : 1-cycle load-return / store-acknowledge pulse
//   axi                  : AXI master port (cpu_sram_axi_bridge_if.master)
// Build option
//   BRIDGE_RDATA_REG_EN  : register R data on the handshake and return it one
//                          cycle later (state RD_RET). Without it the read
//                          data and read data_ok are combinational from R.
// ---------------------------------------------------------------------------
// state   | meaning
// IDLE    | arbitrate; data_req beats inst_req; latch request
// RD_AR   | arvalid high until arready
// RD_R    | rready high until rvalid
// RD_RET  | registered read data returned with data_ok (option only)
// WR_AW_W | awvalid/wvalid high, each dropped after its own handshake
// WR_B    | bready high until bvalid; data_data_ok with bvalid
// ---------------------------------------------------------------------------
module cpu_sram_axi_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_data_ok,

  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_data_ok,

  cpu_sram_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_AR   = 3'd1,
    RD_R    = 3'd2,
    RD_RET  = 3'd3,
    WR_AW_W = 3'd4,
    WR_B    = 3'd5
  } state_t;

  state_t            state;
  logic              src_inst;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wen_q;
  logic [31:0]       wdata_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              aw_ok;
  logic              w_ok;
  logic              rd_done;
  logic [31:0]       rd_word;

`ifdef BRIDGE_RDATA_REG_EN
  logic [31:0]       rdata_q;
`endif

  // A channel counts as done once its valid has dropped, or if it is
  // handshaking this very cycle.
  assign aw_ok = !awvalid_q || axi.awready;
  assign w_ok  = !wvalid_q  || axi.wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      src_inst  <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 4'b0000;
      wdata_q   <= 32'h0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
`ifdef BRIDGE_RDATA_REG_EN
      rdata_q   <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (data_req) begin
            src_inst <= 1'b0;
            addr_q   <= data_addr;
            wen_q    <= data_wen;
            wdata_q  <= data_wdata;
            if (data_wen == 4'b0000) begin
              arvalid_q <= 1'b1;
              state     <= RD_AR;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR_AW_W;
            end
          end else if (inst_req) begin
            src_inst  <= 1'b1;
            addr_q    <= inst_addr;
            wen_q     <= 4'b0000;
            arvalid_q <= 1'b1;
            state     <= RD_AR;
          end
        end
        RD_AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_R;
          end
        end
        RD_R: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
`ifdef BRIDGE_RDATA_REG_EN
            rdata_q  <= axi.rdata;
            state    <= RD_RET;
`else
            state    <= IDLE;
`endif
          end
        end
        RD_RET: begin
          state <= IDLE;
        end
        WR_AW_W: begin
          if (axi.awready) awvalid_q <= 1'b0;
          if (axi.wready)  wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state    <= WR_B;
          end
        end
        WR_B: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRIDGE_RDATA_REG_EN
  assign rd_done = (state == RD_RET);
  assign rd_word = rdata_q;
`else
  assign rd_done = (state == RD_R) && axi.rvalid;
  assign rd_word = axi.rdata;
`endif

  // Both sources share the returned word; it is only meaningful with the
  // matching data_ok, and only one data_ok can be high at a time.
  assign inst_rdata   = rd_word;
  assign data_rdata   = rd_word;
  assign inst_data_ok = rd_done && src_inst;
  assign data_data_ok = (rd_done && !src_inst) || ((state == WR_B) && axi.bvalid);

  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'd2;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'd2;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;

  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wen_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;

  assign axi.bready  = bready_q;

endmodule
